// File: rtl/cg_sched_pkg.sv
// cg_sched_pkg: shared types and default sizes for the clock-enable scheduler.
//   tile_state_e    : per-tile gate state (CG_ON = clocked, CG_OFF = gated)
//   *_DEF localparams: default values for the cg_sched parameters
package cg_sched_pkg;

    typedef enum logic {
        CG_ON  = 1'b0,
        CG_OFF = 1'b1
    } tile_state_e;

    localparam int N_TILE_DEF      = 4;
    localparam int IDLE_CYCLES_DEF = 8;
    localparam int WAKE_GAP_DEF    = 2;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with an internal rotating pointer.
//   clk_i, rst_ni : clock and asynchronous active-low reset (pointer -> 0)
//   req_i  [N]    : request vector
//   en_i          : arbitration allowed this cycle; grant_o is 0 when low
//   grant_o[N]    : one-hot grant (combinational, valid in the same cycle)
// The search starts at the pointer; after a grant the pointer moves to
// grant index + 1, wrapping to 0 after N-1.
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   idx_w;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx_w   = '0;
        idx     = '0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                // Rotate the search by the pointer, wrapping for non-power-of-2 N.
                idx_w = {1'b0, ptr_q} + (PW+1)'(k);
                if (idx_w >= (PW+1)'(N)) begin
                    idx_w = idx_w - (PW+1)'(N);
                end
                idx = PW'(idx_w);
                if (!found && req_i[idx]) begin
                    found        = 1'b1;
                    grant_o[idx] = 1'b1;
                    ptr_d        = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cg_sched.sv
// cg_sched: clock-enable scheduler for per-tile clock gates.
// Gates a tile after IDLE_CYCLES consecutive idle cycles and re-enables gated
// tiles on request, at most one wake grant per WAKE_GAP cycles (round-robin)
// to bound inrush current.
//   clk          : system clock
//   rstn         : asynchronous active-low reset (all tiles return to ON)
//   busy     [N] : tile has work in flight
//   wake_req [N] : level request to (re)enable a tile
//   force_on     : override, every tile enabled while high
//   clken    [N] : clock-gate enable per tile (registered state decode)
//   wake_ack [N] : one-cycle pulse, tile clock enabled for the requester
//   clk_on   [N] : tile is in the ON state (also the FSM state view)
//   gate_evt_cnt[15:0] : only with CG_SCHED_STATS_EN, counts ON->OFF events
//
// Handshake: wake_req is held high until wake_ack pulses; the ack cycle is the
// transfer. Dropping wake_req before the ack withdraws the request.
module cg_sched
    import cg_sched_pkg::*;
#(
    parameter int N_TILE      = N_TILE_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_GAP    = WAKE_GAP_DEF,
    parameter int CNT_W       = $clog2(IDLE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_TILE-1:0] busy,
    input  logic [N_TILE-1:0] wake_req,
    input  logic              force_on,
    output logic [N_TILE-1:0] clken,
    output logic [N_TILE-1:0] wake_ack,
    output logic [N_TILE-1:0] clk_on
`ifdef CG_SCHED_STATS_EN
    ,
    output logic [15:0]       gate_evt_cnt
`endif
);

    localparam int GAP_W = (WAKE_GAP > 1) ? $clog2(WAKE_GAP) : 1;

    tile_state_e       state_q [N_TILE];
    tile_state_e       state_d [N_TILE];
    logic [CNT_W-1:0]  cnt_q   [N_TILE];
    logic [CNT_W-1:0]  cnt_d   [N_TILE];
    logic [N_TILE-1:0] ack_q, ack_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [N_TILE-1:0] arb_req, arb_grant;
    logic              arb_en;

    rr_arb #(.N(N_TILE)) u_arb (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .req_i   (arb_req),
        .en_i    (arb_en),
        .grant_o (arb_grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        gap_d   = gap_q;
        arb_req = '0;
        // force_on bypasses the stagger entirely, so the arbiter stays idle.
        arb_en  = (gap_q == '0) && !force_on;

        // Busy while OFF is treated as a wake request.
        for (int i = 0; i < N_TILE; i++) begin
            arb_req[i] = (state_q[i] == CG_OFF) && (wake_req[i] || busy[i]);
        end

        if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
        if (|arb_grant) begin
            gap_d = GAP_W'(WAKE_GAP - 1);
        end

        for (int i = 0; i < N_TILE; i++) begin
            if (state_q[i] == CG_ON) begin
                // Request on an already-clocked tile is acked without arbitration.
                ack_d[i] = wake_req[i];
                if (force_on || busy[i] || wake_req[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    if (cnt_q[i] == CNT_W'(IDLE_CYCLES - 1)) begin
                        state_d[i] = CG_OFF;
                    end
                    if (cnt_q[i] != CNT_W'(IDLE_CYCLES)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end else if (force_on) begin
                state_d[i] = CG_ON;
                cnt_d[i]   = '0;
                ack_d[i]   = wake_req[i];
            end else if (arb_grant[i]) begin
                state_d[i] = CG_ON;
                cnt_d[i]   = '0;
                ack_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_TILE; i++) begin
                state_q[i] <= CG_ON;
                cnt_q[i]   <= '0;
            end
            ack_q <= '0;
            gap_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_TILE; i++) begin
            clken[i]  = (state_q[i] == CG_ON);
            clk_on[i] = (state_q[i] == CG_ON);
        end
    end

    assign wake_ack = ack_q;

`ifdef CG_SCHED_STATS_EN
    logic [15:0] evt_q, evt_d;

    // Several tiles may gate in the same cycle; each one counts.
    always_comb begin
        evt_d = evt_q;
        for (int i = 0; i < N_TILE; i++) begin
            if (state_q[i] == CG_ON && state_d[i] == CG_OFF) begin
                evt_d = evt_d + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign gate_evt_cnt = evt_q;
`endif

endmodule

// File: tb/tb_cg_sched.sv
// tb_cg_sched: directed self-checking bench for cg_sched with default
// parameters (N_TILE=4, IDLE_CYCLES=8, WAKE_GAP=2).
module tb_cg_sched;

    logic       clk;
    logic       rstn;
    logic [3:0] busy;
    logic [3:0] wake_req;
    logic       force_on;
    logic [3:0] clken;
    logic [3:0] wake_ack;
    logic [3:0] clk_on;
`ifdef CG_SCHED_STATS_EN
    logic [15:0] gate_evt_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cg_sched dut (
        .clk      (clk),
        .rstn     (rstn),
        .busy     (busy),
        .wake_req (wake_req),
        .force_on (force_on),
        .clken    (clken),
        .wake_ack (wake_ack),
        .clk_on   (clk_on)
`ifdef CG_SCHED_STATS_EN
        ,
        .gate_evt_cnt (gate_evt_cnt)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // expected wake sequence after wake_req=4'b1111 with all tiles gated
    logic [3:0] ack_t   [7];
    logic [3:0] clken_t [7];
    logic [3:0] wreq_t  [7];

    initial begin
        ack_t   = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        clken_t = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111};
        wreq_t  = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};

        // reset
        rstn     = 1'b0;
        busy     = '0;
        wake_req = '0;
        force_on = 1'b0;
        step(2);
        chk("rst_clken", 16'(clken), 16'hf);
        chk("rst_clk_on", 16'(clk_on), 16'hf);
        chk("rst_ack", 16'(wake_ack), 16'h0);
`ifdef CG_SCHED_STATS_EN
        chk("rst_evt_cnt", gate_evt_cnt, 16'd0);
`endif
        rstn = 1'b1;

        // idle gating: ON for edges 1-7, gated at edge 8
        for (int e = 1; e <= 7; e++) begin
            step(1);
            chk("idle_on", 16'(clk_on), 16'hf);
        end
        step(1);
        chk("idle_gate_clken", 16'(clken), 16'h0);
        chk("idle_gate_clk_on", 16'(clk_on), 16'h0);
`ifdef CG_SCHED_STATS_EN
        chk("evt_cnt_4", gate_evt_cnt, 16'd4);
`endif

        // all tiles request at once: grants 0,1,2,3 two cycles apart
        wake_req = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk("rr_ack", 16'(wake_ack), 16'(ack_t[k]));
            chk("rr_clken", 16'(clken), 16'(clken_t[k]));
            wake_req = wreq_t[k];
        end
        // tile 0 re-gates at edge 17, the last tile at edge 23
        step(2);
        chk("rr_regate0", 16'(clken), 16'he);
        step(6);
        chk("rr_regate_all", 16'(clken), 16'h0);

        // single wake of tile 2, one-cycle latency and one-cycle ack
        wake_req = 4'b0100;
        step(1);
        chk("wake2_clken", 16'(clken), 16'h4);
        chk("wake2_ack", 16'(wake_ack), 16'h4);
        wake_req = 4'b0000;
        step(1);
        chk("wake2_ack_width", 16'(wake_ack), 16'h0);
        chk("wake2_hold", 16'(clken), 16'h4);
        step(7);
        chk("wake2_regate", 16'(clken), 16'h0);

        // force_on pulse with a request on tile 0
        force_on = 1'b1;
        wake_req = 4'b0001;
        step(1);
        chk("force_clken", 16'(clken), 16'hf);
        chk("force_ack", 16'(wake_ack), 16'h1);
        force_on = 1'b0;
        wake_req = 4'b0000;
        step(1);
        chk("force_ack_drop", 16'(wake_ack), 16'h0);
        // counters read 7 in the cycle after edge 7 past force; busy[1] rises there
        step(6);
        chk("pre_thresh", 16'(clken), 16'hf);
        busy = 4'b0010;
        step(1);
        chk("busy_thresh", 16'(clken), 16'h2);
        busy = 4'b0000;
        // tile 1 counter restarted: still ON 7 edges later, gated at the 8th
        step(7);
        chk("busy_cnt_restart", 16'(clken), 16'h2);
        step(1);
        chk("busy_regate", 16'(clken), 16'h0);

        // asynchronous reset while tile 3 has a pending request
        wake_req = 4'b1000;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_clken", 16'(clken), 16'hf);
        chk("async_rst_ack", 16'(wake_ack), 16'h0);
        wake_req = 4'b0000;
        step(1);
        chk("rst_hold_ack", 16'(wake_ack), 16'h0);
        rstn = 1'b1;
        step(1);
        chk("post_rst_clk_on", 16'(clk_on), 16'hf);
        chk("post_rst_ack", 16'(wake_ack), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
